alu_op_sequencer: RTL and testbench

- Multi-cycle issue/control unit that drives the datapath ALU.
- Accepts one decoded instruction at a time: opcode, destination/source register numbers, memory address.
- Reads register operands; for memory-register (MR_*) opcodes, fetches the second operand over a req/ack memory read port.
- Presents operands and opcode to the ALU, captures the result and writes it back to the register file.

---
 rtl/alu_op_sequencer_if.sv | 49 ++++
 rtl/alu_op_sequencer.sv | 179 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Bundle of instruction, register-file, memory and ALU signals around the sequencer.
// Pure wiring, no latency of its own.
// Backpressure is carried by instr_ready and mem_ack.
interface alu_op_sequencer_if #(
    parameter int DATA_W   = 16,
    parameter int OPCODE_W = 5,
    parameter int REG_AW   = 3,
    parameter int ADDR_W   = 16
);
    logic                instr_valid;
    logic                instr_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_AW-1:0]   rd;
    logic [REG_AW-1:0]   rs;
    logic [ADDR_W-1:0]   maddr;
    logic [REG_AW-1:0]   rf_ra1;
    logic [REG_AW-1:0]   rf_ra2;
    logic [DATA_W-1:0]   rf_rd1;
    logic [DATA_W-1:0]   rf_rd2;
    logic                mem_req;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic [DATA_W-1:0]   alu_a;
    logic [DATA_W-1:0]   alu_b;
    logic [OPCODE_W-1:0] alu_s;
    logic [DATA_W-1:0]   alu_o;
    logic                rf_we;
    logic [REG_AW-1:0]   rf_wa;
    logic [DATA_W-1:0]   rf_wd;
    logic                done;
    logic                err;

    // Sequencer side
    modport master (
        input  instr_valid, opcode, rd, rs, maddr, rf_rd1, rf_rd2,
               mem_ack, mem_rdata, alu_o,
        output instr_ready, rf_ra1, rf_ra2, mem_req, mem_addr,
               alu_a, alu_b, alu_s, rf_we, rf_wa, rf_wd, done, err
    );

    // Environment side: instruction source, register file, memory, ALU
    modport slave (
        output instr_valid, opcode, rd, rs, maddr, rf_rd1, rf_rd2,
               mem_ack, mem_rdata, alu_o,
        input  instr_ready, rf_ra1, rf_ra2, mem_req, mem_addr,
               alu_a, alu_b, alu_s, rf_we, rf_wa, rf_wd, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multi-cycle issue unit: read regs, optionally fetch operand B from memory, run ALU, write back.
// Latency: done 3 cycles after acceptance (RR), 3+k for memory ops with k MEM cycles.
// Backpressure: instr_ready only in IDLE; MEM stalls until mem_ack (or times out with MEM_TIMEOUT_EN).
module alu_op_sequencer #(
    parameter int DATA_W      = 16,
    parameter int OPCODE_W    = 5,
    parameter int REG_AW      = 3,
    parameter int ADDR_W      = 16,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    alu_op_sequencer_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_MEM  = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;

    // Memory-register opcode encodings; everything else is register-register
    localparam logic [OPCODE_W-1:0] MR_ADDA = OPCODE_W'(5'h10);
    localparam logic [OPCODE_W-1:0] MR_ADDL = OPCODE_W'(5'h11);
    localparam logic [OPCODE_W-1:0] MR_SUBA = OPCODE_W'(5'h12);
    localparam logic [OPCODE_W-1:0] MR_SUBL = OPCODE_W'(5'h13);
    localparam logic [OPCODE_W-1:0] MR_OR   = OPCODE_W'(5'h14);
    localparam logic [OPCODE_W-1:0] MR_AND  = OPCODE_W'(5'h15);
    localparam logic [OPCODE_W-1:0] MR_XOR  = OPCODE_W'(5'h16);

    logic [2:0]          state_q,  state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [REG_AW-1:0]   rd_q,     rd_d;
    logic [REG_AW-1:0]   rs_q,     rs_d;
    logic [ADDR_W-1:0]   maddr_q,  maddr_d;
    logic [DATA_W-1:0]   opa_q,    opa_d;
    logic [DATA_W-1:0]   res_q,    res_d;
    // ALU operand registers double as operand B storage and hold between instructions
    logic [DATA_W-1:0]   alu_a_q,  alu_a_d;
    logic [DATA_W-1:0]   alu_b_q,  alu_b_d;
    logic [OPCODE_W-1:0] alu_s_q,  alu_s_d;
    logic                is_mr;
`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                err_q,    err_d;
`endif

    // Classify the latched opcode
    always_comb begin
        is_mr = 1'b0;
        case (opcode_q)
            MR_ADDA, MR_ADDL, MR_SUBA, MR_SUBL, MR_OR, MR_AND, MR_XOR: is_mr = 1'b1;
            default: is_mr = 1'b0;
        endcase
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        rd_d     = rd_q;
        rs_d     = rs_q;
        maddr_d  = maddr_q;
        opa_d    = opa_q;
        res_d    = res_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_s_d  = alu_s_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    opcode_d = bus.opcode;
                    rd_d     = bus.rd;
                    rs_d     = bus.rs;
                    maddr_d  = bus.maddr;
                    state_d  = S_RD;
                end
            end
            S_RD: begin
                opa_d = bus.rf_rd1;
                if (is_mr) begin
`ifdef MEM_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    state_d = S_MEM;
                end else begin
                    alu_a_d = bus.rf_rd1;
                    alu_b_d = bus.rf_rd2;
                    alu_s_d = opcode_q;
                    state_d = S_EX;
                end
            end
            S_MEM: begin
                // An ack always wins over a timeout landing in the same cycle
                if (bus.mem_ack) begin
                    alu_a_d = opa_q;
                    alu_b_d = bus.mem_rdata;
                    alu_s_d = opcode_q;
                    state_d = S_EX;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_EX: begin
                res_d   = bus.alu_o;
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            rd_q     <= '0;
            rs_q     <= '0;
            maddr_q  <= '0;
            opa_q    <= '0;
            res_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_s_q  <= '0;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            rd_q     <= rd_d;
            rs_q     <= rs_d;
            maddr_q  <= maddr_d;
            opa_q    <= opa_d;
            res_q    <= res_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_s_q  <= alu_s_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.rf_ra1      = rd_q;
    assign bus.rf_ra2      = rs_q;
    assign bus.mem_req     = (state_q == S_MEM);
    assign bus.mem_addr    = maddr_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_s       = alu_s_q;
    assign bus.rf_we       = (state_q == S_WB);
    assign bus.rf_wa       = rd_q;
    assign bus.rf_wd       = res_q;
    assign bus.done        = (state_q == S_WB);
`ifdef MEM_TIMEOUT_EN
    assign bus.err         = err_q;
`else
    assign bus.err         = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer with register file, memory and ALU models.
// Expected results come from a per-instruction reference computed from the opcode rules.
// Memory ack delay is randomized to exercise MEM stalls.
module tb_alu_op_sequencer;
    localparam int DW = 16;
    localparam int OW = 5;
    localparam int RW = 3;
    localparam int AW = 16;

    localparam logic [OW-1:0] RR_ADDA = 5'h00;
    localparam logic [OW-1:0] RR_SUBA = 5'h02;
    localparam logic [OW-1:0] RR_XOR  = 5'h06;
    localparam logic [OW-1:0] MR_ADDA = 5'h10;
    localparam logic [OW-1:0] MR_OR   = 5'h14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(DW), .OPCODE_W(OW), .REG_AW(RW), .ADDR_W(AW)) bus();

    alu_op_sequencer #(
        .DATA_W(DW), .OPCODE_W(OW), .REG_AW(RW), .ADDR_W(AW), .TIMEOUT_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] rf     [8];
    logic [DW-1:0] ref_rf [8];
    logic          pl_we = 1'b0;
    logic [RW-1:0] pl_wa = '0;
    logic [DW-1:0] pl_wd = '0;

    // Environment register file: bench preload port or DUT writeback
    always @(posedge clk) begin
        if (pl_we) rf[pl_wa] <= pl_wd;
        else if (bus.rf_we) rf[bus.rf_wa] <= bus.rf_wd;
    end

    function automatic logic [DW-1:0] alu_fn(input logic [OW-1:0] op,
                                             input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            5'h00, 5'h01, 5'h10, 5'h11: return a + b;
            5'h02, 5'h03, 5'h12, 5'h13: return a - b;
            5'h04, 5'h14:               return a | b;
            5'h05, 5'h15:               return a & b;
            5'h06, 5'h16:               return a ^ b;
            default:                    return ~(a ^ b) + 16'h0101;
        endcase
    endfunction

    function automatic bit is_mr(input logic [OW-1:0] op);
        return (op >= 5'h10) && (op <= 5'h16);
    endfunction

    assign bus.rf_rd1 = rf[bus.rf_ra1];
    assign bus.rf_rd2 = rf[bus.rf_ra2];
    assign bus.alu_o  = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [RW-1:0] r, input logic [DW-1:0] v);
        pl_we = 1'b1;
        pl_wa = r;
        pl_wd = v;
        tick();
        pl_we = 1'b0;
        ref_rf[r] = v;
    endtask

    // Busy-time noise: offers and acks that must be ignored
    task automatic junk();
        bus.instr_valid = 1'b1;
        bus.opcode      = OW'($urandom);
        bus.rd          = RW'($urandom);
        bus.rs          = RW'($urandom);
        bus.maddr       = AW'($urandom);
        bus.mem_ack     = 1'($urandom_range(0, 1));
        bus.mem_rdata   = DW'($urandom);
    endtask

    // One instruction from IDLE back to IDLE; k = MEM cycles including the ack cycle
    task automatic run_op(input logic [OW-1:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                          input logic [AW-1:0] ma, input logic [DW-1:0] md, input int k);
        logic [DW-1:0] a, b, exp;
        bit mr;
        mr  = is_mr(op);
        a   = ref_rf[rd];
        b   = mr ? md : ref_rf[rs];
        exp = alu_fn(op, a, b);
        check("ready_idle", 32'(bus.instr_ready), 32'(1));
        bus.instr_valid = 1'b1;
        bus.opcode      = op;
        bus.rd          = rd;
        bus.rs          = rs;
        bus.maddr       = ma;
        bus.mem_ack     = 1'b0;
        tick();
        check("ready_busy", 32'(bus.instr_ready), 32'(0));
        check("rf_ra1", 32'(bus.rf_ra1), 32'(rd));
        check("rf_ra2", 32'(bus.rf_ra2), 32'(rs));
        check("rd_mem_req", 32'(bus.mem_req), 32'(0));
        junk();
        tick();
        if (mr) begin
            for (int i = 0; i < k; i++) begin
                check("mem_req", 32'(bus.mem_req), 32'(1));
                check("mem_addr", 32'(bus.mem_addr), 32'(ma));
                check("mem_err", 32'(bus.err), 32'(0));
                bus.mem_ack   = (i == k - 1);
                bus.mem_rdata = (i == k - 1) ? md : DW'($urandom);
                tick();
            end
            junk();
        end
        check("ex_mem_req", 32'(bus.mem_req), 32'(0));
        check("alu_a", 32'(bus.alu_a), 32'(a));
        check("alu_b", 32'(bus.alu_b), 32'(b));
        check("alu_s", 32'(bus.alu_s), 32'(op));
        check("ex_done", 32'(bus.done), 32'(0));
        tick();
        check("rf_we", 32'(bus.rf_we), 32'(1));
        check("rf_wa", 32'(bus.rf_wa), 32'(rd));
        check("rf_wd", 32'(bus.rf_wd), 32'(exp));
        check("done", 32'(bus.done), 32'(1));
        check("wb_ready", 32'(bus.instr_ready), 32'(0));
        bus.instr_valid = 1'b0;
        bus.mem_ack     = 1'b0;
        ref_rf[rd]      = exp;
        tick();
        check("idle_done", 32'(bus.done), 32'(0));
        check("idle_we", 32'(bus.rf_we), 32'(0));
        check("idle_err", 32'(bus.err), 32'(0));
        check("hold_alu_a", 32'(bus.alu_a), 32'(a));
        check("hold_alu_s", 32'(bus.alu_s), 32'(op));
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = '0;
        bus.rd          = '0;
        bus.rs          = '0;
        bus.maddr       = '0;
        bus.mem_ack     = 1'b0;
        bus.mem_rdata   = '0;
        #1;
        check("rst_ready", 32'(bus.instr_ready), 32'(1));
        check("rst_mem_req", 32'(bus.mem_req), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_alu_a", 32'(bus.alu_a), 32'(0));
        check("rst_err", 32'(bus.err), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 8; r++) preload(RW'(r), DW'($urandom));

        // Directed cases
        preload(3'd1, 16'h0005);
        preload(3'd2, 16'h0003);
        run_op(RR_SUBA, 3'd1, 3'd2, 16'h0000, 16'h0000, 1);
        preload(3'd4, 16'h00F0);
        run_op(MR_OR, 3'd4, 3'd0, 16'h0010, 16'h000F, 3);
        preload(3'd3, 16'h1234);
        run_op(RR_XOR, 3'd3, 3'd3, 16'h0000, 16'h0000, 1);
        run_op(RR_ADDA, 3'd5, 3'd6, 16'h0000, 16'h0000, 1);
        run_op(RR_ADDA, 3'd5, 3'd5, 16'h0000, 16'h0000, 1);
        run_op(5'h1F, 3'd7, 3'd2, 16'h0000, 16'h0000, 1);
        run_op(MR_ADDA, 3'd0, 3'd0, 16'hBEEF, 16'h7FFF, 1);
        run_op(MR_ADDA, 3'd6, 3'd1, 16'h1234, 16'h0101, 4);
        check("rf_r3_zero", 32'(rf[3]), 32'(0));

        // Reset while waiting in MEM
        bus.instr_valid = 1'b1;
        bus.opcode      = MR_OR;
        bus.rd          = 3'd2;
        bus.maddr       = 16'h0040;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        check("pre_rst_mem_req", 32'(bus.mem_req), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(bus.instr_ready), 32'(1));
        check("arst_mem_req", 32'(bus.mem_req), 32'(0));
        check("arst_we", 32'(bus.rf_we), 32'(0));
        check("arst_done", 32'(bus.done), 32'(0));
        check("arst_alu_a", 32'(bus.alu_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(bus.instr_ready), 32'(1));

`ifdef MEM_TIMEOUT_EN
        // Memory never answers: err after 4 MEM cycles, no writeback
        bus.instr_valid = 1'b1;
        bus.opcode      = MR_ADDA;
        bus.rd          = 3'd1;
        bus.maddr       = 16'h0F00;
        bus.mem_ack     = 1'b0;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_mem_req", 32'(bus.mem_req), 32'(1));
            check("to_err_early", 32'(bus.err), 32'(0));
            check("to_we", 32'(bus.rf_we), 32'(0));
            tick();
        end
        check("to_err", 32'(bus.err), 32'(1));
        check("to_mem_req_drop", 32'(bus.mem_req), 32'(0));
        check("to_ready", 32'(bus.instr_ready), 32'(1));
        check("to_done", 32'(bus.done), 32'(0));
        tick();
        check("to_err_pulse", 32'(bus.err), 32'(0));
        check("to_rf_kept", 32'(rf[1]), 32'(ref_rf[1]));
`endif

        // Random instruction mix
        for (int n = 0; n < 60; n++) begin
            run_op(OW'($urandom_range(0, 31)), RW'($urandom), RW'($urandom),
                   AW'($urandom), DW'($urandom), $urandom_range(1, 4));
        end
        for (int r = 0; r < 8; r++) check("final_rf", 32'(rf[r]), 32'(ref_rf[r]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
